// File: rtl/javk_biu.sv
// javk_biu: owns the external bus and arbitrates core data accesses (priority) over an instruction prefetch queue.
// Every access holds the bus for WAIT+1 cycles; mem_ready pulses the cycle after; prefetch stalls while the queue has no free slot.
module javk_biu #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 16,
  parameter int                PQ_DEPTH = 4,
  parameter int                WAIT     = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] databus,
  output logic [ADDR_W-1:0] addrbus,
  output logic              rw,
  output logic [DATA_W-1:0] instr_data,
  output logic              instr_valid,
  input  logic              instr_pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata
);

  localparam int         PW      = $clog2(PQ_DEPTH);
  localparam int         CW      = PW + 1;
  localparam logic [2:0] WAIT_M1 = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, ACCESS, WAITST} state_t;

  state_t            state_q, state_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic              cur_mem_q, cur_mem_d;
  logic              discard_q, discard_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pf_q, pf_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdy_q, rdy_d;
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     occ_q, occ_d, occ_after;
  logic [CW:0]       need;
  logic [DATA_W-1:0] pq_mem [PQ_DEPTH];

  logic busy, last, can_start, req_ok, pop_ok, push, pf_pend, pf_ok;

  always_comb begin
    busy      = (state_q != IDLE);
    last      = ((state_q == ACCESS) && (WAIT == 0)) || ((state_q == WAITST) && (wcnt_q == 3'd0));
    can_start = !busy || last;
    // The request that is completing (or just completed) must not be re-issued.
    req_ok    = mem_req && !rdy_q && !(busy && cur_mem_q);
    pop_ok    = instr_pop && (occ_q != '0) && !flush;
    push      = busy && last && !cur_mem_q && !discard_q && !flush;
    pf_pend   = busy && !cur_mem_q && !discard_q;
    occ_after = occ_q - CW'(pop_ok);
    need      = {1'b0, occ_after} + (CW+1)'(pf_pend);
    pf_ok     = !req_ok && !flush && (need < (CW+1)'(PQ_DEPTH));
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    cur_mem_d = cur_mem_q;
    discard_d = discard_q;
    addr_d    = addr_q;
    pf_d      = pf_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rdy_d     = 1'b0;

    if (busy && last && cur_mem_q) begin
      rdy_d = 1'b1;
      if (!rw_q) rdata_d = databus;
    end

    if (can_start) begin
      discard_d = 1'b0;
      cur_mem_d = 1'b0;
      if (req_ok) begin
        state_d   = ACCESS;
        cur_mem_d = 1'b1;
        addr_d    = mem_addr;
        rw_d      = mem_we;
        wdata_d   = mem_wdata;
      end else if (pf_ok) begin
        state_d = ACCESS;
        addr_d  = pf_q;
        rw_d    = 1'b0;
        pf_d    = pf_q + 1'b1;
      end else begin
        state_d = IDLE;
        rw_d    = 1'b0;
      end
    end else if (state_q == ACCESS) begin
      state_d = WAITST;
      wcnt_d  = WAIT_M1;
    end else begin
      wcnt_d = wcnt_q - 3'd1;
    end

    // A prefetch cut short by flush still runs its bus cycles; only its data is dropped.
    if (flush) begin
      pf_d = flush_pc;
      if (busy && !cur_mem_q && !last) discard_d = 1'b1;
    end

    occ_d = flush ? '0 : occ_q + CW'(push) - CW'(pop_ok);
    rd_d  = flush ? '0 : rd_q + PW'(pop_ok);
    wr_d  = flush ? '0 : wr_q + PW'(push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= 3'd0;
      cur_mem_q <= 1'b0;
      discard_q <= 1'b0;
      addr_q    <= '0;
      pf_q      <= RESET_PC;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rdy_q     <= 1'b0;
      rd_q      <= '0;
      wr_q      <= '0;
      occ_q     <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      cur_mem_q <= cur_mem_d;
      discard_q <= discard_d;
      addr_q    <= addr_d;
      pf_q      <= pf_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rdy_q     <= rdy_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      occ_q     <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) pq_mem[wr_q] <= databus;
  end

  assign databus     = rw_q ? wdata_q : 'z;
  assign addrbus     = addr_q;
  assign rw          = rw_q;
  assign instr_data  = pq_mem[rd_q];
  assign instr_valid = (occ_q != '0);
  assign mem_ready   = rdy_q;
  assign mem_rdata   = rdata_q;

endmodule

// File: tb/tb_javk_biu.sv
// Bench for javk_biu: directed vector table plus hand sequences, then random traffic against a stream/memory model.
module tb_javk_biu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  logic        instr_pop = 1'b0, flush = 1'b0;
  logic [15:0] flush_pc = 16'h0;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr = 16'h0;
  logic [7:0]  mem_wdata = 8'h0;
  logic        req0 = 1'b0, req_a = 1'b0, req_b = 1'b0;

  wire  [7:0]  db0, db_a, db_b;
  logic [15:0] ab0, ab_a, ab_b;
  logic        rw0, rw_a, rw_b;
  logic [7:0]  id0, id_a, id_b;
  logic        iv0, iv_a, iv_b;
  logic        rdy0, rdy_a, rdy_b;
  logic [7:0]  rd0, rd_a, rd_b;

  javk_biu #(.DATA_W(8), .ADDR_W(16), .PQ_DEPTH(4), .WAIT(1), .RESET_PC(16'h0000)) u0 (
    .clk(clk), .rst(rst), .databus(db0), .addrbus(ab0), .rw(rw0),
    .instr_data(id0), .instr_valid(iv0), .instr_pop(instr_pop), .flush(flush), .flush_pc(flush_pc),
    .mem_req(req0), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(rdy0), .mem_rdata(rd0));

  javk_biu #(.DATA_W(8), .ADDR_W(16), .PQ_DEPTH(4), .WAIT(0), .RESET_PC(16'h0000)) u_w0 (
    .clk(clk), .rst(rst), .databus(db_a), .addrbus(ab_a), .rw(rw_a),
    .instr_data(id_a), .instr_valid(iv_a), .instr_pop(1'b0), .flush(1'b0), .flush_pc(16'h0000),
    .mem_req(req_a), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(rdy_a), .mem_rdata(rd_a));

  javk_biu #(.DATA_W(8), .ADDR_W(16), .PQ_DEPTH(4), .WAIT(3), .RESET_PC(16'h0000)) u_w3 (
    .clk(clk), .rst(rst), .databus(db_b), .addrbus(ab_b), .rw(rw_b),
    .instr_data(id_b), .instr_valid(iv_b), .instr_pop(1'b0), .flush(1'b0), .flush_pc(16'h0000),
    .mem_req(req_b), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(rdy_b), .mem_rdata(rd_b));

  // External memory: answers reads whenever the BIU is not writing, captures writes at the clock edge.
  assign db0  = rw0  ? 8'bzzzzzzzz : mem[ab0];
  assign db_a = rw_a ? 8'bzzzzzzzz : mem[ab_a];
  assign db_b = rw_b ? 8'bzzzzzzzz : mem[ab_b];
  always @(posedge clk) if (rw0) mem[ab0] = db0;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [7:0] f(input logic [15:0] a);
    if (a == 16'h00FF) return 8'h5C;
    return (a[7:0] + 8'h10) ^ a[15:8];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tfail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired, got no event, expected one", name);
  endtask

  task automatic pop_one(input string nm, input logic [7:0] exp);
    int n = 0;
    while (!iv0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " valid"}, 32'(iv0), 32'd1);
    chk(nm, 32'(id0), 32'(exp));
    instr_pop = 1'b1;
    @(negedge clk);
    instr_pop = 1'b0;
  endtask

  typedef struct {
    logic        pop;
    logic        req;
    logic [15:0] e_ab;
    logic        e_rw;
    logic        e_iv;
    logic        e_rdy;
    logic        chk_id;
    logic [7:0]  e_id;
  } vec_t;

  function automatic vec_t mk(input logic pop, input logic req, input logic [15:0] ea, input logic erw,
                              input logic eiv, input logic erdy, input logic cid, input logic [7:0] eid);
    vec_t v;
    v.pop = pop; v.req = req; v.e_ab = ea; v.e_rw = erw;
    v.e_iv = eiv; v.e_rdy = erdy; v.chk_id = cid; v.e_id = eid;
    return v;
  endfunction

  vec_t        vt [16];
  int          pend, p_age, lat_a, lat_b, pul_a, pul_b, nwait;
  logic        p_we, pflush;
  logic [7:0]  p_exp;
  logic [15:0] mpc;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 65536; a++) begin
      mem[a]     = f(16'(a));
      ref_mem[a] = f(16'(a));
    end

    // Fill, then pop-triggered refetch, then a store arriving mid-prefetch.
    vt[0]  = mk(0, 0, 16'h0000, 0, 0, 0, 0, 8'h00);
    vt[1]  = mk(0, 0, 16'h0000, 0, 0, 0, 0, 8'h00);
    vt[2]  = mk(0, 0, 16'h0001, 0, 1, 0, 1, 8'h10);
    vt[3]  = mk(0, 0, 16'h0001, 0, 1, 0, 1, 8'h10);
    vt[4]  = mk(0, 0, 16'h0002, 0, 1, 0, 1, 8'h10);
    vt[5]  = mk(0, 0, 16'h0002, 0, 1, 0, 1, 8'h10);
    vt[6]  = mk(0, 0, 16'h0003, 0, 1, 0, 1, 8'h10);
    vt[7]  = mk(0, 0, 16'h0003, 0, 1, 0, 1, 8'h10);
    vt[8]  = mk(0, 0, 16'h0003, 0, 1, 0, 1, 8'h10);
    vt[9]  = mk(1, 0, 16'h0003, 0, 1, 0, 1, 8'h10);
    vt[10] = mk(0, 1, 16'h0004, 0, 1, 0, 1, 8'h11);
    vt[11] = mk(0, 1, 16'h0004, 0, 1, 0, 1, 8'h11);
    vt[12] = mk(0, 1, 16'h1234, 1, 1, 0, 1, 8'h11);
    vt[13] = mk(0, 1, 16'h1234, 1, 1, 0, 1, 8'h11);
    vt[14] = mk(0, 0, 16'h1234, 0, 1, 1, 1, 8'h11);
    vt[15] = mk(0, 0, 16'h1234, 0, 1, 0, 1, 8'h11);

    #3;
    chk("reset addrbus", 32'(ab0), 32'h0);
    chk("reset rw", 32'(rw0), 32'h0);
    chk("reset instr_valid", 32'(iv0), 32'h0);
    chk("reset mem_ready", 32'(rdy0), 32'h0);
    chk("reset mem_rdata", 32'(rd0), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    mem_we = 1'b1; mem_addr = 16'h1234; mem_wdata = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d addrbus", i), 32'(ab0), 32'(vt[i].e_ab));
      chk($sformatf("vec%0d rw", i), 32'(rw0), 32'(vt[i].e_rw));
      chk($sformatf("vec%0d instr_valid", i), 32'(iv0), 32'(vt[i].e_iv));
      chk($sformatf("vec%0d mem_ready", i), 32'(rdy0), 32'(vt[i].e_rdy));
      if (vt[i].chk_id) chk($sformatf("vec%0d instr_data", i), 32'(id0), 32'(vt[i].e_id));
      if (vt[i].e_rw) chk($sformatf("vec%0d databus", i), 32'(db0), 32'hA5);
      instr_pop = vt[i].pop;
      req0      = vt[i].req;
    end
    chk("store landed", 32'(mem[16'h1234]), 32'hA5);

    // Flush while the fetch at 5 sits in its wait state; then flush a fetch in its first cycle.
    instr_pop = 1'b1;
    @(negedge clk);
    chk("refetch addr 5", 32'(ab0), 32'h5);
    instr_pop = 1'b0;
    @(negedge clk);
    chk("fetch 5 waitst", 32'(ab0), 32'h5);
    flush = 1'b1; flush_pc = 16'h0200;
    @(negedge clk);
    chk("flush empties", 32'(iv0), 32'h0);
    flush = 1'b0;
    @(negedge clk);
    chk("fetch at flush_pc", 32'(ab0), 32'h0200);
    chk("flushed byte dropped", 32'(iv0), 32'h0);
    @(negedge clk);
    chk("still empty", 32'(iv0), 32'h0);
    @(negedge clk);
    chk("flush_pc byte valid", 32'(iv0), 32'h1);
    chk("flush_pc byte", 32'(id0), 32'(f(16'h0200)));
    chk("next fetch 0x201", 32'(ab0), 32'h0201);
    flush = 1'b1; flush_pc = 16'hFFFE;
    @(negedge clk);
    chk("wrap flush empties", 32'(iv0), 32'h0);
    flush = 1'b0;
    @(negedge clk);
    chk("wrap first fetch", 32'(ab0), 32'hFFFE);
    chk("0x201 dropped", 32'(iv0), 32'h0);
    @(negedge clk);
    pop_one("wrap pop0", f(16'hFFFE));
    pop_one("wrap pop1", f(16'hFFFF));
    pop_one("wrap pop2", f(16'h0000));
    pop_one("wrap pop3", f(16'h0001));

    // Loads on the WAIT=0 and WAIT=3 instances, both long idle with full queues.
    mem_we = 1'b0; mem_addr = 16'h00FF;
    req_a = 1'b1; req_b = 1'b1;
    lat_a = 0; lat_b = 0; pul_a = 0; pul_b = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk("w0 load addr", 32'(ab_a), 32'h00FF);
        chk("w3 load addr", 32'(ab_b), 32'h00FF);
        chk("w3 load rw", 32'(rw_b), 32'h0);
      end
      if (rdy_a) begin
        pul_a++;
        if (lat_a == 0) begin lat_a = n; chk("w0 rdata", 32'(rd_a), 32'h5C); end
        req_a = 1'b0;
      end
      if (rdy_b) begin
        pul_b++;
        if (lat_b == 0) begin lat_b = n; chk("w3 rdata", 32'(rd_b), 32'h5C); end
        req_b = 1'b0;
      end
    end
    chk("w0 ready latency", 32'(lat_a), 32'd2);
    chk("w3 ready latency", 32'(lat_b), 32'd5);
    chk("w0 ready pulses", 32'(pul_a), 32'd1);
    chk("w3 ready pulses", 32'(pul_b), 32'd1);
    chk("w3 rdata holds", 32'(rd_b), 32'h5C);

    // Random traffic: instruction stream must follow flush_pc onward; loads must see the model memory.
    mpc = 16'h0002; pend = 0; p_age = 0; pflush = 1'b0; p_we = 1'b0; p_exp = 8'h0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (pflush) chk("rand flush empties", 32'(iv0), 32'h0);
      pflush = 1'b0;
      if (rdy0) begin
        chk("rand ready expected", 32'(pend), 32'd1);
        if (pend != 0 && !p_we) chk("rand load data", 32'(rd0), 32'(p_exp));
        req0 = 1'b0; pend = 0;
      end else if (pend != 0) begin
        p_age++;
        if (p_age > 20) begin tfail("rand ready timeout"); req0 = 1'b0; pend = 0; end
      end else if ($urandom_range(0, 7) == 0) begin
        p_we = 1'($urandom_range(0, 1));
        if (p_we || $urandom_range(0, 1) == 1) mem_addr = {8'h80, 8'($urandom)};
        else mem_addr = 16'($urandom_range(0, 16'h3FFF));
        mem_wdata = 8'($urandom);
        mem_we = p_we;
        if (p_we) ref_mem[mem_addr] = mem_wdata;
        else p_exp = ref_mem[mem_addr];
        req0 = 1'b1; pend = 1; p_age = 0;
      end
      if ($urandom_range(0, 39) == 0) begin
        flush = 1'b1; flush_pc = 16'($urandom_range(0, 16'h3FFF));
        mpc = flush_pc; instr_pop = 1'b0; pflush = 1'b1;
      end else begin
        flush = 1'b0;
        if (iv0 && $urandom_range(0, 1) == 1) begin
          chk("rand instr stream", 32'(id0), 32'(ref_mem[mpc]));
          mpc = mpc + 16'd1;
          instr_pop = 1'b1;
        end else begin
          instr_pop = 1'b0;
        end
      end
    end
    flush = 1'b0; instr_pop = 1'b0;
    nwait = 0;
    while (pend != 0 && nwait < 30) begin
      @(negedge clk);
      nwait++;
      if (rdy0) begin
        if (!p_we) chk("rand last load", 32'(rd0), 32'(p_exp));
        req0 = 1'b0; pend = 0;
      end
    end
    if (pend != 0) begin tfail("rand drain"); req0 = 1'b0; end
    for (int a = 0; a < 256; a++)
      chk("store image", 32'(mem[16'h8000 + a]), 32'(ref_mem[16'h8000 + a]));

    // Async reset in the middle of a store.
    @(negedge clk);
    mem_we = 1'b1; mem_addr = 16'h8123; mem_wdata = 8'h3C; req0 = 1'b1;
    nwait = 0;
    while (!rw0 && nwait < 30) begin
      @(negedge clk);
      nwait++;
    end
    chk("store before reset", 32'(rw0), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async rst rw", 32'(rw0), 32'h0);
    chk("async rst addrbus", 32'(ab0), 32'h0);
    chk("async rst valid", 32'(iv0), 32'h0);
    chk("async rst ready", 32'(rdy0), 32'h0);
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post rst fetch 0", 32'(ab0), 32'h0);
    chk("post rst rw", 32'(rw0), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("post rst fetch 1", 32'(ab0), 32'h1);
    chk("post rst valid", 32'(iv0), 32'h1);
    chk("post rst head", 32'(id0), 32'h10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
